mp_mac_accum: RTL and testbench
===============================

MP_MAC_ACCUM -- requirements
Module: mp_mac_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 32: width of each accumulator lane.
REQ-002 SHALL have parameter LO_W, default 12: width of the low packed sub-product field.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  begin a new accumulation (honoured in IDLE only).
REQ-006 SHALL have port count_i  input  8  number of products to accumulate, sampled with start_i.
REQ-007 SHALL have port packed_i  input  1  1 = packed dual sub-product mode, 0 = normal full product, sampled with start_i.
REQ-008 SHALL have port prod_valid_i  input  1  multiplier product valid.
REQ-009 SHALL have port prod_ready_o  output  1  block accepts product this cycle.
REQ-010 SHALL have port prod_i  input  34  signed product from the 17x17 multiplier stage, sign correction already applied.
REQ-011 SHALL have port res_valid_o  output  1  result lanes valid.
REQ-012 SHALL have port res_ready_i  input  1  consumer takes result.
REQ-013 SHALL have ports res_lo_o and res_hi_o  output  ACC_W each  signed lane sums.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-015 SHALL have port ovf_o  output  1  sticky saturation flag for the current run.

Function
REQ-016 States SHALL be IDLE, ACCUM, DONE.
REQ-017 IDLE with start_i=1 and count_i!=0: clear both lanes and ovf_o, latch count_i and packed_i, go to ACCUM next cycle.
REQ-018 IDLE with start_i=1 and count_i==0: clear lanes, go directly to DONE, result zeros.
REQ-019 start_i in ACCUM or DONE SHALL be ignored; latched mode and count SHALL not change.
REQ-020 prod_ready_o SHALL be 1 exactly in ACCUM; a product is accepted on prod_valid_i & prod_ready_o.
REQ-021 Normal mode: res_lo += prod_i (34-bit signed), res_hi unchanged (0).
REQ-022 Packed mode: res_lo += sign-extend(prod_i[LO_W-1:0]); res_hi += sign-extend(prod_i[33:LO_W]); both in the same cycle.
REQ-023 Remaining count SHALL decrement per accepted product; acceptance of the last product SHALL move to DONE.
REQ-024 res_valid_o SHALL assert the cycle after the last product is accepted (latency 1) and hold, with stable lanes, until res_ready_i=1.
REQ-025 DONE with res_ready_i=1: go to IDLE next cycle; res_lo_o/res_hi_o SHALL hold their values in IDLE until the next start.
REQ-026 prod_valid_i gaps in ACCUM SHALL stall without state change; products outside ACCUM SHALL be ignored.

Reset
REQ-027 rst_i=1 at any time, including mid-ACCUM or in DONE, SHALL force IDLE, lanes 0, count 0, res_valid_o=0, prod_ready_o=0, busy_o=0, ovf_o=0, in-flight run discarded.

Configuration
REQ-028 Macro MP_MAC_SAT_EN defined: each lane sum SHALL be computed at ACC_W+3 bits and clamped to the signed ACC_W range; any clamp SHALL set ovf_o until next start or reset.
REQ-029 MP_MAC_SAT_EN undefined: lane sums SHALL wrap modulo 2^ACC_W; ovf_o SHALL be tied to 0.

Structure
REQ-030 Package mp_mac_pkg SHALL hold the state enum, ACC_W/LO_W defaults and the 34-bit product typedef.
REQ-031 One sub-module mp_mac_lane (add + optional saturate, one lane) SHALL be instantiated twice.

Verification
REQ-032 Normal, count=3, products 100, -50, 7 -> res_lo=57, res_hi=0, res_valid_o one cycle after third accept.
REQ-033 Packed, count=2, prod_i = {22'sd5,12'sd-3} twice -> res_lo=-6, res_hi=10.
REQ-034 start_i with count_i=0 -> DONE next cycle, res_valid_o=1, lanes 0, no product accepted.
REQ-035 SAT_EN, normal, lane at 0x7FFFFFF0, product +0x100 -> res_lo=0x7FFFFFFF, ovf_o=1; without macro -> 0x800000F0, ovf_o=0.
REQ-036 rst_i pulsed after 2 of 4 products accepted -> IDLE, all outputs 0; new start runs cleanly.
REQ-037 res_ready_i held 0 for 5 cycles in DONE -> res_valid_o and lanes stable; start_i pulses ignored.

Source files
------------

// File: rtl/mp_mac_pkg.sv
// Shared types and defaults for the mixed-precision MAC accumulator.
package mp_mac_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int LO_W_DEF  = 12;
   localparam int PROD_W    = 34;

   // Signed product as delivered by the 17x17 multiplier stage.
   typedef logic signed [PROD_W-1:0] prod_t;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/mp_mac_lane.sv
// One accumulator lane: adds a sign-extended product term to the running sum.
// With MP_MAC_SAT_EN defined, the sum is formed with three guard bits and
// clamped to the signed ACC_W range, and 'clamp' reports a clamp event.
// Without it, the sum wraps modulo 2^ACC_W and 'clamp' is always 0.
module mp_mac_lane
   import mp_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] acc,
   input  prod_t            addend,
   output logic [ACC_W-1:0] sum,
   output logic             clamp
);

   // Wide enough for ACC_W plus three guard bits and for the full product term.
   localparam int SUM_W = (ACC_W + 3 > PROD_W + 1) ? (ACC_W + 3) : (PROD_W + 1);

   logic signed [SUM_W-1:0] acc_ext_s;
   logic signed [SUM_W-1:0] add_ext_s;
   logic signed [SUM_W-1:0] wide_s;

   assign acc_ext_s = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
   assign add_ext_s = {{(SUM_W-PROD_W){addend[PROD_W-1]}}, addend};
   assign wide_s    = acc_ext_s + add_ext_s;

`ifdef MP_MAC_SAT_EN
   localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_S = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

   // Clamp the wide sum into the signed lane range and flag any clamp.
   always_comb begin
      sum   = wide_s[ACC_W-1:0];
      clamp = 1'b0;
      if (wide_s > MAX_S) begin
         sum   = {1'b0, {(ACC_W-1){1'b1}}};
         clamp = 1'b1;
      end else if (wide_s < MIN_S) begin
         sum   = {1'b1, {(ACC_W-1){1'b0}}};
         clamp = 1'b1;
      end else begin
         sum   = wide_s[ACC_W-1:0];
         clamp = 1'b0;
      end
   end
`else
   // Guard bits are deliberately discarded: the lane wraps.
   logic unused_s;
   assign unused_s = ^wide_s[SUM_W-1:ACC_W];
   assign sum      = wide_s[ACC_W-1:0];
   assign clamp    = 1'b0;
`endif

endmodule

// File: rtl/mp_mac_accum.sv
// Mixed-precision MAC accumulator: sums a programmed number of 34-bit signed
// products into two lanes. Normal mode adds the full product into the low
// lane; packed mode splits each product into a LO_W-bit low field and the
// remaining high field and accumulates both in the same cycle.
// Optional feature macro: MP_MAC_SAT_EN (saturating lanes with sticky ovf_o).
module mp_mac_accum
   import mp_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LO_W  = LO_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [7:0]       count_i,
   input  logic             packed_i,
   input  logic             prod_valid_i,
   output logic             prod_ready_o,
   input  logic [33:0]      prod_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [ACC_W-1:0] res_lo_o,
   output logic [ACC_W-1:0] res_hi_o,
   output logic             busy_o,
   output logic             ovf_o
);

   state_e           state_r;
   logic [7:0]       cnt_r;
   logic             packed_r;
   logic [ACC_W-1:0] lo_r;
   logic [ACC_W-1:0] hi_r;
   logic             ovf_r;

   prod_t            lo_add_s;
   prod_t            hi_add_s;
   logic [ACC_W-1:0] lo_sum_s;
   logic [ACC_W-1:0] hi_sum_s;
   logic             lo_clamp_s;
   logic             hi_clamp_s;

   // Select the per-lane addends from the incoming product for the latched mode.
   always_comb begin
      lo_add_s = prod_i;
      hi_add_s = {PROD_W{1'b0}};
      if (packed_r) begin
         lo_add_s = {{(PROD_W-LO_W){prod_i[LO_W-1]}}, prod_i[LO_W-1:0]};
         hi_add_s = {{LO_W{prod_i[PROD_W-1]}}, prod_i[PROD_W-1:LO_W]};
      end else begin
         lo_add_s = prod_i;
         hi_add_s = {PROD_W{1'b0}};
      end
   end

   mp_mac_lane #(.ACC_W(ACC_W)) u_lane_lo (
      .acc    (lo_r),
      .addend (lo_add_s),
      .sum    (lo_sum_s),
      .clamp  (lo_clamp_s)
   );

   mp_mac_lane #(.ACC_W(ACC_W)) u_lane_hi (
      .acc    (hi_r),
      .addend (hi_add_s),
      .sum    (hi_sum_s),
      .clamp  (hi_clamp_s)
   );

   // Run controller: start/latch in IDLE, accumulate accepted products, hold result in DONE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 8'd0;
         packed_r <= 1'b0;
         lo_r     <= {ACC_W{1'b0}};
         hi_r     <= {ACC_W{1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  lo_r     <= {ACC_W{1'b0}};
                  hi_r     <= {ACC_W{1'b0}};
                  ovf_r    <= 1'b0;
                  cnt_r    <= count_i;
                  packed_r <= packed_i;
                  state_r  <= (count_i == 8'd0) ? ST_DONE : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (prod_valid_i) begin
                  lo_r  <= lo_sum_s;
                  hi_r  <= hi_sum_s;
                  ovf_r <= ovf_r | lo_clamp_s | hi_clamp_s;
                  cnt_r <= cnt_r - 8'd1;
                  if (cnt_r == 8'd1) begin
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (res_ready_i) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode directly from registered state, so they are glitch-free.
   assign prod_ready_o = (state_r == ST_ACCUM);
   assign res_valid_o  = (state_r == ST_DONE);
   assign busy_o       = (state_r != ST_IDLE);
   assign res_lo_o     = lo_r;
   assign res_hi_o     = hi_r;
   assign ovf_o        = ovf_r;

endmodule

// File: tb/tb_mp_mac_accum.sv
// Self-checking bench for mp_mac_accum with a plain-arithmetic reference model.
// Honours MP_MAC_SAT_EN for its expected values.
module tb_mp_mac_accum;

   localparam int ACC_W = 32;
   localparam int LO_W  = 12;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [7:0]       count_i;
   logic             packed_i;
   logic             prod_valid_i;
   logic             prod_ready_o;
   logic [33:0]      prod_i;
   logic             res_valid_o;
   logic             res_ready_i;
   logic [ACC_W-1:0] res_lo_o;
   logic [ACC_W-1:0] res_hi_o;
   logic             busy_o;
   logic             ovf_o;

   mp_mac_accum #(.ACC_W(ACC_W), .LO_W(LO_W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .count_i      (count_i),
      .packed_i     (packed_i),
      .prod_valid_i (prod_valid_i),
      .prod_ready_o (prod_ready_o),
      .prod_i       (prod_i),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .res_lo_o     (res_lo_o),
      .res_hi_o     (res_hi_o),
      .busy_o       (busy_o),
      .ovf_o        (ovf_o)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   int          total = 0;
   int          bad   = 0;
   longint      m_lo;
   longint      m_hi;
   bit          m_ovf;
   bit          m_packed;
   logic [33:0] pq[$];

   // Bring a mathematical sum back into the lane range (wrap or clamp).
   function automatic longint norm(input longint v, output bit clamped);
      logic [31:0] t;
`ifdef MP_MAC_SAT_EN
      t = 32'd0;
      if (v > 64'sd2147483647) begin
         clamped = 1'b1;
         return 64'sd2147483647;
      end else if (v < -64'sd2147483648) begin
         clamped = 1'b1;
         return -64'sd2147483648;
      end else begin
         clamped = 1'b0;
         return v;
      end
`else
      t = v[31:0];
      clamped = 1'b0;
      return longint'($signed(t));
`endif
   endfunction

   // Reference model: account for one accepted product.
   task automatic model_accept(input logic [33:0] p);
      logic signed [33:0] full;
      logic signed [11:0] lf;
      logic signed [21:0] hf;
      bit c1, c2;
      full = p;
      lf   = p[11:0];
      hf   = p[33:12];
      c2   = 1'b0;
      if (m_packed) begin
         m_lo = norm(m_lo + longint'(lf), c1);
         m_hi = norm(m_hi + longint'(hf), c2);
      end else begin
         m_lo = norm(m_lo + longint'(full), c1);
      end
      m_ovf = m_ovf | c1 | c2;
   endtask

   // Start a run over pq, feed it with random valid gaps, hold DONE, then release.
   task automatic run_and_check(input string tag, input bit pk, input int cnt,
                                input int hold, input bit poke_start);
      int          idx;
      int          cyc;
      bit          v;
      logic [31:0] e_lo;
      logic [31:0] e_hi;
      m_lo = 0; m_hi = 0; m_ovf = 1'b0; m_packed = pk;
      @(negedge clk_i);
      start_i = 1'b1; count_i = cnt[7:0]; packed_i = pk; prod_valid_i = 1'b0;
      @(negedge clk_i);
      start_i = 1'b0; count_i = 8'($urandom); packed_i = 1'($urandom);
      idx = 0; cyc = 0;
      while (idx < cnt && cyc < cnt * 8 + 50) begin
         total++;
         if ({prod_ready_o, res_valid_o, busy_o} !== 3'b101) begin
            bad++;
            $display("FAIL %s accum_flags: got %b want 101", tag, {prod_ready_o, res_valid_o, busy_o});
         end
         v = ($urandom_range(0, 3) != 32'd0);
         prod_valid_i = v;
         prod_i = v ? pq[idx] : 34'({$urandom, $urandom});
         @(negedge clk_i);
         if (v) begin
            model_accept(pq[idx]);
            idx++;
         end
         cyc++;
      end
      prod_valid_i = 1'b0;
      if (idx < cnt) begin
         total++; bad++;
         $display("FAIL %s timeout: accepted %0d want %0d", tag, idx, cnt);
      end
      e_lo = m_lo[31:0];
      e_hi = m_hi[31:0];
      total++;
      if ({prod_ready_o, res_valid_o, busy_o} !== 3'b011) begin
         bad++;
         $display("FAIL %s done_flags: got %b want 011", tag, {prod_ready_o, res_valid_o, busy_o});
      end
      total++;
      if (res_lo_o !== e_lo || res_hi_o !== e_hi || ovf_o !== m_ovf) begin
         bad++;
         $display("FAIL %s result: got lo=%h hi=%h ovf=%b want lo=%h hi=%h ovf=%b",
                  tag, res_lo_o, res_hi_o, ovf_o, e_lo, e_hi, m_ovf);
      end
      for (int h = 0; h < hold; h++) begin
         prod_valid_i = 1'($urandom);
         prod_i = 34'({$urandom, $urandom});
         start_i = poke_start ? 1'($urandom) : 1'b0;
         count_i = 8'($urandom);
         packed_i = 1'($urandom);
         res_ready_i = 1'b0;
         @(negedge clk_i);
         total++;
         if (res_valid_o !== 1'b1 || prod_ready_o !== 1'b0 || res_lo_o !== e_lo ||
             res_hi_o !== e_hi || ovf_o !== m_ovf) begin
            bad++;
            $display("FAIL %s hold%0d: got v=%b r=%b lo=%h hi=%h want v=1 r=0 lo=%h hi=%h",
                     tag, h, res_valid_o, prod_ready_o, res_lo_o, res_hi_o, e_lo, e_hi);
         end
      end
      start_i = 1'b0; prod_valid_i = 1'b0; res_ready_i = 1'b1;
      @(negedge clk_i);
      res_ready_i = 1'b0;
      total++;
      if ({prod_ready_o, res_valid_o, busy_o} !== 3'b000 || res_lo_o !== e_lo || res_hi_o !== e_hi) begin
         bad++;
         $display("FAIL %s release: got flags=%b lo=%h hi=%h want flags=000 lo=%h hi=%h",
                  tag, {prod_ready_o, res_valid_o, busy_o}, res_lo_o, res_hi_o, e_lo, e_hi);
      end
      prod_valid_i = 1'b1;
      prod_i = 34'({$urandom, $urandom});
      @(negedge clk_i);
      prod_valid_i = 1'b0;
      total++;
      if (busy_o !== 1'b0 || res_lo_o !== e_lo || res_hi_o !== e_hi || ovf_o !== m_ovf) begin
         bad++;
         $display("FAIL %s idle_hold: got busy=%b lo=%h hi=%h want busy=0 lo=%h hi=%h",
                  tag, busy_o, res_lo_o, res_hi_o, e_lo, e_hi);
      end
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      total++;
      if ({prod_ready_o, res_valid_o, busy_o, ovf_o} !== 4'b0000 || res_lo_o !== 32'd0 || res_hi_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_hold: got flags=%b lo=%h hi=%h want zeros",
                  {prod_ready_o, res_valid_o, busy_o, ovf_o}, res_lo_o, res_hi_o);
      end
      rst_i = 1'b0;
      @(negedge clk_i);
      total++;
      if ({prod_ready_o, res_valid_o, busy_o, ovf_o} !== 4'b0000 || res_lo_o !== 32'd0 || res_hi_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_release: got flags=%b lo=%h hi=%h want zeros",
                  {prod_ready_o, res_valid_o, busy_o, ovf_o}, res_lo_o, res_hi_o);
      end
   endtask

   task automatic test_normal();
      pq = {34'sd100, -34'sd50, 34'sd7};
      run_and_check("normal", 1'b0, 3, 2, 1'b0);
      total++;
      if (res_lo_o !== 32'd57 || res_hi_o !== 32'd0) begin
         bad++;
         $display("FAIL normal_const: got lo=%h hi=%h want lo=00000039 hi=00000000", res_lo_o, res_hi_o);
      end
   endtask

   task automatic test_packed();
      logic [33:0] p;
      p = {22'd5, 12'hFFD};
      pq = {p, p};
      run_and_check("packed", 1'b1, 2, 1, 1'b0);
      total++;
      if (res_lo_o !== 32'hFFFF_FFFA || res_hi_o !== 32'd10) begin
         bad++;
         $display("FAIL packed_const: got lo=%h hi=%h want lo=fffffffa hi=0000000a", res_lo_o, res_hi_o);
      end
   endtask

   task automatic test_zero_count();
      pq = {};
      run_and_check("zero", 1'b1, 0, 3, 1'b1);
      total++;
      if (res_lo_o !== 32'd0 || res_hi_o !== 32'd0) begin
         bad++;
         $display("FAIL zero_const: got lo=%h hi=%h want zeros", res_lo_o, res_hi_o);
      end
   endtask

   task automatic test_sat_boundary();
      logic [31:0] want_lo;
      logic        want_ovf;
`ifdef MP_MAC_SAT_EN
      want_lo = 32'h7FFF_FFFF; want_ovf = 1'b1;
`else
      want_lo = 32'h8000_00F0; want_ovf = 1'b0;
`endif
      pq = {34'h0_7FFF_FFF0, 34'h0_0000_0100};
      run_and_check("sat", 1'b0, 2, 0, 1'b0);
      total++;
      if (res_lo_o !== want_lo || ovf_o !== want_ovf) begin
         bad++;
         $display("FAIL sat_const: got lo=%h ovf=%b want lo=%h ovf=%b", res_lo_o, ovf_o, want_lo, want_ovf);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i);
      start_i = 1'b1; count_i = 8'd4; packed_i = 1'($urandom);
      @(negedge clk_i);
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         prod_valid_i = 1'b1;
         prod_i = 34'({$urandom, $urandom});
         @(negedge clk_i);
      end
      prod_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      total++;
      if ({prod_ready_o, res_valid_o, busy_o, ovf_o} !== 4'b0000 || res_lo_o !== 32'd0 || res_hi_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid: got flags=%b lo=%h hi=%h want zeros",
                  {prod_ready_o, res_valid_o, busy_o, ovf_o}, res_lo_o, res_hi_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      total++;
      if ({prod_ready_o, res_valid_o, busy_o} !== 3'b000 || res_lo_o !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_idle: got flags=%b lo=%h want zeros",
                  {prod_ready_o, res_valid_o, busy_o}, res_lo_o);
      end
      pq = {34'sd11, -34'sd4, 34'sd1000};
      run_and_check("after_reset", 1'b0, 3, 1, 1'b0);
   endtask

   task automatic test_random();
      int n;
      bit pk;
      logic [63:0] r;
      for (int run = 0; run < 10; run++) begin
         n  = $urandom_range(1, 20);
         pk = 1'($urandom);
         pq = {};
         for (int i = 0; i < n; i++) begin
            r = {$urandom, $urandom};
            if (r[40]) pq.push_back(r[33:0]);
            else       pq.push_back({{18{r[15]}}, r[15:0]});
         end
         run_and_check($sformatf("rand%0d", run), pk, n, $urandom_range(0, 3), 1'b1);
      end
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; count_i = 8'd0; packed_i = 1'b0;
      prod_valid_i = 1'b0; prod_i = 34'd0; res_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      test_reset();
      test_normal();
      test_packed();
      test_zero_count();
      test_sat_boundary();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
